// File: rtl/spi_cfg_master_if.sv
// Request/response bus of the SPI configuration master.
//
// Handshake: a request is accepted on a rising clk edge where
// req_valid && req_ready. req_ready is high only while the master is idle.
// A requester may hold req_valid high; it will be accepted on the first
// idle cycle. rsp_valid is a single-cycle pulse with rsp_rdata valid in the
// same cycle. rsp_rdata then holds until the next rsp_valid. busy is high
// from the cycle after accept until req_ready returns high.
interface spi_cfg_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [12:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        busy;

  modport master (
    output req_valid, req_rw, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/spi_cfg_master.sv
// SPI configuration master: 24-bit frames {rw, W1:W0=00, addr[12:0], data[7:0]},
// MSB first, 3-wire SDIO with turnaround after the 16-bit instruction on reads.
// sclk idles low; sdio_o changes on sclk falling edges and sdio_i is sampled
// in the first cycle of each sclk high phase.
module spi_cfg_master #(
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             resetn,
  spi_cfg_master_if.slave  req_if,
  output logic             sclk,
  output logic             ss_n,
  output logic             sdio_o,
  output logic             sdio_t,
  input  logic             sdio_i,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;        // half-period counter 0..CLK_DIV-1
  logic [4:0]  bit_q;        // bit index 0..23 in SHIFT, half index 0..1 in GAP
  logic [22:0] frame_q;      // remaining frame bits; bit 23 goes straight to sdio_o
  logic        rw_q;
  logic [7:0]  rx_q;
  logic        ready_q;
  logic        busy_q;
  logic        rsp_valid_q;
  logic [7:0]  rsp_rdata_q;
  logic        sclk_q;
  logic        ss_n_q;
  logic        sdio_o_q;
  logic        sdio_t_q;
  logic        half_end;

  assign half_end = (cnt_q == HALF_LAST);

  // Frame sequencer: IDLE -> SETUP -> SHIFT -> GAP -> IDLE, all outputs registered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      bit_q       <= 5'd0;
      frame_q     <= 23'd0;
      rw_q        <= 1'b0;
      rx_q        <= 8'h00;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      sclk_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      sdio_o_q    <= 1'b0;
      sdio_t_q    <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // ready_q is high throughout IDLE, so valid alone means accept
          if (req_if.req_valid) begin
            state_q  <= SETUP;
            frame_q  <= {2'b00, req_if.req_addr, req_if.req_wdata};
            rw_q     <= req_if.req_rw;
            rx_q     <= 8'h00;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            ss_n_q   <= 1'b0;
            sdio_t_q <= 1'b0;
            sdio_o_q <= req_if.req_rw;
            cnt_q    <= 8'd0;
            bit_q    <= 5'd0;
          end
        end
        SETUP: begin
          if (half_end) begin
            state_q <= SHIFT;
            sclk_q  <= 1'b1;
            cnt_q   <= 8'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        SHIFT: begin
          // Read data bits 17..24 are captured at the start of their high phase
          if (sclk_q && (cnt_q == 8'd0) && rw_q && (bit_q >= 5'd16)) begin
            rx_q <= {rx_q[6:0], sdio_i};
          end
          if (!half_end) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            cnt_q <= 8'd0;
            if (sclk_q) begin
              // Falling edge: present the next bit, or turn the line around
              sclk_q <= 1'b0;
              if (bit_q != 5'd23) begin
                frame_q <= {frame_q[21:0], 1'b0};
                if (rw_q && (bit_q >= 5'd15)) begin
                  sdio_t_q <= 1'b1;
                  sdio_o_q <= 1'b0;
                end else begin
                  sdio_o_q <= frame_q[22];
                end
              end
            end else if (bit_q == 5'd23) begin
              state_q     <= GAP;
              bit_q       <= 5'd0;
              ss_n_q      <= 1'b1;
              sdio_t_q    <= 1'b1;
              sdio_o_q    <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rw_q ? rx_q : 8'h00;
            end else begin
              sclk_q <= 1'b1;
              bit_q  <= bit_q + 5'd1;
            end
          end
        end
        GAP: begin
          // Two half-periods of deselect time before the next frame
          if (!half_end) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            cnt_q <= 8'd0;
            if (bit_q == 5'd1) begin
              state_q <= IDLE;
              bit_q   <= 5'd0;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              bit_q <= 5'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_if.req_ready = ready_q;
  assign req_if.busy      = busy_q;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_rdata = rsp_rdata_q;
  assign sclk             = sclk_q;
  assign ss_n             = ss_n_q;
  assign sdio_o           = sdio_o_q;
  assign sdio_t           = sdio_t_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Testbench for spi_cfg_master: one instance at CLK_DIV=4 for timing and
// protocol scenarios, one at CLK_DIV=2 for register loopback, sharing a
// behavioural SPI slave selected by 'sel'.
module tb_spi_cfg_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  spi_cfg_master_if bus4();
  spi_cfg_master_if bus2();

  logic        v4 = 1'b0, v2 = 1'b0, rw = 1'b0;
  logic [12:0] addr = 13'h0;
  logic [7:0]  wdata = 8'h00;
  logic        mi = 1'b0;
  logic        sclk4, ss4, mo4, t4, sclk2, ss2, mo2, t2;
  logic [1:0]  st4, st2;

  assign bus4.req_valid = v4;
  assign bus4.req_rw    = rw;
  assign bus4.req_addr  = addr;
  assign bus4.req_wdata = wdata;
  assign bus2.req_valid = v2;
  assign bus2.req_rw    = rw;
  assign bus2.req_addr  = addr;
  assign bus2.req_wdata = wdata;

  spi_cfg_master #(.CLK_DIV(4)) dut4 (
    .clk(clk), .resetn(resetn), .req_if(bus4), .sclk(sclk4), .ss_n(ss4),
    .sdio_o(mo4), .sdio_t(t4), .sdio_i(mi), .dbg_state_o(st4)
  );

  spi_cfg_master #(.CLK_DIV(2)) dut2 (
    .clk(clk), .resetn(resetn), .req_if(bus2), .sclk(sclk2), .ss_n(ss2),
    .sdio_o(mo2), .sdio_t(t2), .sdio_i(mi), .dbg_state_o(st2)
  );

  // Selected-instance view (0 = CLK_DIV 4, 1 = CLK_DIV 2)
  bit sel = 1'b0;
  logic       m_sclk, m_ss, m_mo, m_t, m_rsp, m_ready, m_busy;
  logic [7:0] m_rdata;
  logic [1:0] m_state;
  assign m_sclk  = sel ? sclk2 : sclk4;
  assign m_ss    = sel ? ss2 : ss4;
  assign m_mo    = sel ? mo2 : mo4;
  assign m_t     = sel ? t2 : t4;
  assign m_rsp   = sel ? bus2.rsp_valid : bus4.rsp_valid;
  assign m_ready = sel ? bus2.req_ready : bus4.req_ready;
  assign m_busy  = sel ? bus2.busy : bus4.busy;
  assign m_rdata = sel ? bus2.rsp_rdata : bus4.rsp_rdata;
  assign m_state = sel ? st2 : st4;

  // ---------------- SPI slave register model ----------------
  logic [7:0]  mem [int];
  logic [23:0] s_sh = 24'h0, s_tb = 24'h0, last_frame = 24'h0, last_t = 24'h0;
  int          s_cnt = 0, last_cnt = 0, s_frames = 0;
  logic        s_rw = 1'b0;
  logic [7:0]  s_rd = 8'h00;
  logic        p_sclk = 1'b0, p_ss = 1'b1;

  always @(negedge clk) begin
    if (!m_ss && p_ss) begin
      s_cnt = 0; s_sh = 24'h0; s_tb = 24'h0; s_rw = 1'b0;
    end
    if (!m_ss && m_sclk && !p_sclk) begin
      s_sh = {s_sh[22:0], m_mo};
      s_tb = {s_tb[22:0], m_t};
      s_cnt++;
    end
    if (!m_ss && !m_sclk && p_sclk) begin
      if (s_cnt == 16) begin
        s_rw = s_sh[15];
        s_rd = mem.exists(int'(s_sh[12:0])) ? mem[int'(s_sh[12:0])] : (s_sh[7:0] ^ 8'h83);
      end
      if (s_rw && s_cnt >= 16 && s_cnt < 24) mi = s_rd[23 - s_cnt];
    end
    if (m_ss && !p_ss) begin
      last_frame = s_sh; last_t = s_tb; last_cnt = s_cnt; s_frames++;
      if (s_cnt == 24 && !s_sh[23]) mem[int'(s_sh[20:8])] = s_sh[7:0];
      mi = 1'b0;
    end
    p_sclk = m_sclk;
    p_ss   = m_ss;
  end

  // ---------------- scoreboard counters / transaction results ----------------
  int n_cmp = 0, n_bad = 0;
  int r_fall, r_rise, r_rsp, r_rdy, r_nrsp, r_busy_err;
  logic [7:0] r_rd;
  logic r_mo1, r_ab_ss, r_ab_t, r_ab_sclk;

  // ---------------- driver ----------------
  // Cycle 0 is the accept cycle; t counts negedges after it.
  task automatic do_txn(input bit rw_i, input logic [12:0] a, input logic [7:0] d,
                        input int pulse_t, input int rst_t);
    logic p;
    @(negedge clk);
    rw = rw_i; addr = a; wdata = d;
    if (sel) v2 = 1'b1; else v4 = 1'b1;
    r_fall = -1; r_rise = -1; r_rsp = -1; r_rdy = -1; r_nrsp = 0; r_busy_err = 0;
    r_rd = 8'h00; r_mo1 = 1'bx; r_ab_ss = 1'bx; r_ab_t = 1'bx; r_ab_sclk = 1'bx;
    p = 1'b1;
    for (int t = 1; t <= 600 && r_rdy < 0; t++) begin
      @(negedge clk);
      if (t == 1) begin v4 = 1'b0; v2 = 1'b0; r_mo1 = m_mo; end
      if (t == pulse_t) begin
        rw = ~rw_i; addr = ~a; wdata = ~d;
        if (sel) v2 = 1'b1; else v4 = 1'b1;
      end
      if (t == pulse_t + 1) begin v4 = 1'b0; v2 = 1'b0; end
      if (t == rst_t) resetn = 1'b0;
      if (t == rst_t + 1) begin
        resetn = 1'b1; r_ab_ss = m_ss; r_ab_t = m_t; r_ab_sclk = m_sclk;
      end
      if (!m_ss && p) r_fall = t;
      if (m_ss && !p) r_rise = t;
      if (m_rsp) begin r_nrsp++; r_rsp = t; r_rd = m_rdata; end
      if (m_busy !== !m_ready) r_busy_err++;
      if (m_ready) r_rdy = t;
      p = m_ss;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      n_cmp++; if (m_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready[%0d] got %b want 1", s, m_ready); end
      n_cmp++; if (m_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy[%0d] got %b want 0", s, m_busy); end
      n_cmp++; if (m_ss !== 1'b1) begin n_bad++; $display("FAIL rst_ss_n[%0d] got %b want 1", s, m_ss); end
      n_cmp++; if (m_sclk !== 1'b0) begin n_bad++; $display("FAIL rst_sclk[%0d] got %b want 0", s, m_sclk); end
      n_cmp++; if (m_t !== 1'b1) begin n_bad++; $display("FAIL rst_sdio_t[%0d] got %b want 1", s, m_t); end
      n_cmp++; if (m_mo !== 1'b0) begin n_bad++; $display("FAIL rst_sdio_o[%0d] got %b want 0", s, m_mo); end
      n_cmp++; if (m_rsp !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid[%0d] got %b want 0", s, m_rsp); end
      n_cmp++; if (m_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rdata[%0d] got %h want 00", s, m_rdata); end
      n_cmp++; if (m_state !== 2'd0) begin n_bad++; $display("FAIL rst_state[%0d] got %0d want 0", s, m_state); end
    end
    sel = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_write();
    sel = 1'b0;
    do_txn(1'b0, 13'h0014, 8'hA5, -10, -10);
    n_cmp++; if (r_fall !== 1) begin n_bad++; $display("FAIL wr_ss_fall got %0d want 1", r_fall); end
    n_cmp++; if (r_rise !== 197) begin n_bad++; $display("FAIL wr_ss_rise got %0d want 197", r_rise); end
    n_cmp++; if (r_rsp !== 197) begin n_bad++; $display("FAIL wr_rsp_cycle got %0d want 197", r_rsp); end
    n_cmp++; if (r_rdy !== 205) begin n_bad++; $display("FAIL wr_ready_cycle got %0d want 205", r_rdy); end
    n_cmp++; if (r_nrsp !== 1) begin n_bad++; $display("FAIL wr_rsp_count got %0d want 1", r_nrsp); end
    n_cmp++; if (r_rd !== 8'h00) begin n_bad++; $display("FAIL wr_rdata got %h want 00", r_rd); end
    n_cmp++; if (r_mo1 !== 1'b0) begin n_bad++; $display("FAIL wr_setup_bit got %b want 0", r_mo1); end
    n_cmp++; if (last_frame !== 24'h0014A5) begin n_bad++; $display("FAIL wr_mosi got %h want 0014a5", last_frame); end
    n_cmp++; if (last_cnt !== 24) begin n_bad++; $display("FAIL wr_sclk_count got %0d want 24", last_cnt); end
    n_cmp++; if (last_t !== 24'h000000) begin n_bad++; $display("FAIL wr_sdio_t got %h want 000000", last_t); end
    n_cmp++; if (r_busy_err !== 0) begin n_bad++; $display("FAIL wr_busy got %0d bad cycles want 0", r_busy_err); end
  endtask

  task automatic test_read();
    sel = 1'b0;
    do_txn(1'b1, 13'h0001, 8'hFF, -10, -10);
    n_cmp++; if (r_mo1 !== 1'b1) begin n_bad++; $display("FAIL rd_setup_bit got %b want 1", r_mo1); end
    n_cmp++; if (last_frame !== 24'h800100) begin n_bad++; $display("FAIL rd_instr got %h want 800100", last_frame); end
    n_cmp++; if (last_t !== 24'h0000FF) begin n_bad++; $display("FAIL rd_sdio_t got %h want 0000ff", last_t); end
    n_cmp++; if (r_rd !== 8'h82) begin n_bad++; $display("FAIL rd_rdata got %h want 82", r_rd); end
    n_cmp++; if (r_rsp !== 197) begin n_bad++; $display("FAIL rd_rsp_cycle got %0d want 197", r_rsp); end
    n_cmp++; if (r_rdy !== 205) begin n_bad++; $display("FAIL rd_ready_cycle got %0d want 205", r_rdy); end
    repeat (3) @(negedge clk);
    n_cmp++; if (m_rdata !== 8'h82) begin n_bad++; $display("FAIL rd_rdata_hold got %h want 82", m_rdata); end
  endtask

  task automatic test_back_to_back();
    int fall2, rise1, nfall, nrsp, f0;
    logic p;
    sel = 1'b0;
    @(negedge clk);
    rw = 1'b0; addr = 13'h0040; wdata = 8'h12; v4 = 1'b1;
    fall2 = -1; rise1 = -1; nfall = 0; nrsp = 0; f0 = s_frames; p = 1'b1;
    for (int t = 1; t <= 460; t++) begin
      @(negedge clk);
      if (t == 1) begin addr = 13'h0041; wdata = 8'h34; end
      if (!m_ss && p) begin
        nfall++;
        if (nfall == 2) begin fall2 = t; v4 = 1'b0; end
      end
      if (m_ss && !p && rise1 < 0) rise1 = t;
      if (m_rsp) nrsp++;
      p = m_ss;
    end
    v4 = 1'b0;
    n_cmp++; if (fall2 - rise1 !== 9) begin n_bad++; $display("FAIL b2b_gap got %0d want 9", fall2 - rise1); end
    n_cmp++; if (nfall !== 2) begin n_bad++; $display("FAIL b2b_frames got %0d want 2", nfall); end
    n_cmp++; if (nrsp !== 2) begin n_bad++; $display("FAIL b2b_rsp_count got %0d want 2", nrsp); end
    n_cmp++; if (s_frames - f0 !== 2) begin n_bad++; $display("FAIL b2b_slave_frames got %0d want 2", s_frames - f0); end
    n_cmp++; if (last_frame !== 24'h004134) begin n_bad++; $display("FAIL b2b_second got %h want 004134", last_frame); end
    n_cmp++; if (!mem.exists(64) || mem[64] !== 8'h12) begin n_bad++; $display("FAIL b2b_first got %h want 12", mem.exists(64) ? mem[64] : 8'hxx); end
  endtask

  task automatic test_ignore();
    int f0;
    sel = 1'b0;
    f0 = s_frames;
    do_txn(1'b0, 13'h0AAA, 8'h3C, 100, -10);
    repeat (30) @(negedge clk);
    n_cmp++; if (last_frame !== 24'h0AAA3C) begin n_bad++; $display("FAIL ign_frame got %h want 0aaa3c", last_frame); end
    n_cmp++; if (r_nrsp !== 1) begin n_bad++; $display("FAIL ign_rsp_count got %0d want 1", r_nrsp); end
    n_cmp++; if (s_frames - f0 !== 1) begin n_bad++; $display("FAIL ign_frames got %0d want 1", s_frames - f0); end
    n_cmp++; if (r_rsp !== 197) begin n_bad++; $display("FAIL ign_rsp_cycle got %0d want 197", r_rsp); end
  endtask

  task automatic test_reset_abort();
    int nrsp, nlow, w0;
    sel = 1'b0;
    w0 = mem.num();
    do_txn(1'b1, 13'h0001, 8'h00, -10, 78);
    nrsp = 0; nlow = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (m_rsp) nrsp++;
      if (!m_ss) nlow++;
    end
    n_cmp++; if (r_ab_ss !== 1'b1) begin n_bad++; $display("FAIL abort_ss_n got %b want 1", r_ab_ss); end
    n_cmp++; if (r_ab_t !== 1'b1) begin n_bad++; $display("FAIL abort_sdio_t got %b want 1", r_ab_t); end
    n_cmp++; if (r_ab_sclk !== 1'b0) begin n_bad++; $display("FAIL abort_sclk got %b want 0", r_ab_sclk); end
    n_cmp++; if (r_rise !== 79) begin n_bad++; $display("FAIL abort_rise got %0d want 79", r_rise); end
    n_cmp++; if (last_cnt !== 10) begin n_bad++; $display("FAIL abort_bits got %0d want 10", last_cnt); end
    n_cmp++; if (r_nrsp + nrsp !== 0) begin n_bad++; $display("FAIL abort_rsp got %0d want 0", r_nrsp + nrsp); end
    n_cmp++; if (nlow !== 0) begin n_bad++; $display("FAIL abort_restart got %0d low cycles want 0", nlow); end
    n_cmp++; if (mem.num() !== w0) begin n_bad++; $display("FAIL abort_mem got %0d entries want %0d", mem.num(), w0); end
    do_txn(1'b0, 13'h0007, 8'h5A, -10, -10);
    n_cmp++; if (r_rsp !== 197) begin n_bad++; $display("FAIL post_abort_rsp got %0d want 197", r_rsp); end
    n_cmp++; if (last_frame !== 24'h00075A) begin n_bad++; $display("FAIL post_abort_frame got %h want 00075a", last_frame); end
  endtask

  task automatic test_loopback();
    logic [12:0] la [4] = '{13'h0003, 13'h0100, 13'h1FFF, 13'h0A5A};
    logic [7:0]  ld [4] = '{8'h11, 8'hEE, 8'h7E, 8'h96};
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_txn(1'b0, la[i], ld[i], -10, -10);
      n_cmp++; if (r_rsp !== 99) begin n_bad++; $display("FAIL lb_wr_rsp[%0d] got %0d want 99", i, r_rsp); end
      n_cmp++; if (r_rdy !== 103) begin n_bad++; $display("FAIL lb_wr_ready[%0d] got %0d want 103", i, r_rdy); end
    end
    for (int i = 0; i < 4; i++) begin
      do_txn(1'b1, la[i], 8'h00, -10, -10);
      n_cmp++; if (r_rd !== ld[i]) begin n_bad++; $display("FAIL lb_rd[%0d] got %h want %h", i, r_rd, ld[i]); end
      n_cmp++; if (r_nrsp !== 1) begin n_bad++; $display("FAIL lb_rd_rsp[%0d] got %0d want 1", i, r_nrsp); end
    end
    sel = 1'b0;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_ignore();
    test_reset_abort();
    test_loopback();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_cfg_master.md
SPI_CFG_MASTER -- requirements
Module: spi_cfg_master

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per SPI clock half-period; legal range 2..255.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 resetn  in  1  synchronous active-low reset.
REQ-005 req_valid  in  1  transaction request.
REQ-006 req_ready  out  1  high only in IDLE; accept = req_valid && req_ready at a clk edge.
REQ-007 req_rw  in  1  1 = read, 0 = write.
REQ-008 req_addr  in  13  register address.
REQ-009 req_wdata  in  8  write data; ignored for reads.
REQ-010 rsp_valid  out  1  one-cycle pulse at transaction completion.
REQ-011 rsp_rdata  out  8  read byte; 8'h00 after writes; held until next rsp_valid.
REQ-012 busy  out  1  high from the cycle after accept until req_ready returns high.
REQ-013 sclk  out  1  SPI clock; idle low.
REQ-014 ss_n  out  1  SPI chip select, active low.
REQ-015 sdio_o  out  1  serial data to the IO buffer.
REQ-016 sdio_t  out  1  buffer tristate: 1 = input (high-Z), 0 = drive.
REQ-017 sdio_i  in  1  serial data from the IO buffer.

Function
REQ-018 Frame SHALL be 24 bits, MSB first: {req_rw, 2'b00 (W1:W0, one byte), req_addr[12:0], data[7:0]}.
REQ-019 On accept, req_rw/req_addr/req_wdata SHALL be latched; input changes afterwards have no effect.
REQ-020 States: IDLE -> SETUP -> SHIFT -> GAP -> IDLE; no other states are reachable.
REQ-021 IDLE: ss_n=1, sclk=0, sdio_t=1, sdio_o=0, req_ready=1.
REQ-022 SETUP: entered the cycle after accept; ss_n=0, sclk=0, sdio_t=0, sdio_o=frame bit 23; lasts CLK_DIV cycles.
REQ-023 SHIFT: for each of the 24 bits, sclk is high for CLK_DIV cycles, then low for CLK_DIV cycles; total 48*CLK_DIV cycles.
REQ-024 sdio_o SHALL change only on the first cycle of each sclk low phase (falling edge), to the next frame bit.
REQ-025 Read: sdio_t SHALL go to 1 at the falling edge ending bit 16 and stay 1 until IDLE; sdio_o=0 while sdio_t=1.
REQ-026 Read: sdio_i SHALL be sampled in the first cycle of each sclk high phase of bits 17..24, shifted MSB first.
REQ-027 Write: sdio_t SHALL remain 0 for all 24 bits.
REQ-028 GAP: entered after the last low phase; ss_n=1, sclk=0, sdio_t=1; lasts 2*CLK_DIV cycles; rsp_valid pulses on the first GAP cycle.
REQ-029 With accept at cycle 0: ss_n falls at cycle 1, rsp_valid at cycle 1+49*CLK_DIV, req_ready high at cycle 1+51*CLK_DIV.
REQ-030 req_valid while req_ready=0 SHALL be ignored, neither queued nor acknowledged.
REQ-031 Back-to-back requests: a request held high during GAP SHALL be accepted on the first IDLE cycle.
REQ-032 Counters: half-period counter 0..CLK_DIV-1 and bit counter 0..23 SHALL wrap to 0 on state exit, never beyond.

Reset
REQ-033 While resetn=0 at a clk edge, the block SHALL enter IDLE with its outputs at the IDLE values of REQ-021, plus rsp_valid=0, rsp_rdata=8'h00, busy=0.
REQ-034 Reset during SETUP, SHIFT or GAP SHALL abort the frame: ss_n=1 the next cycle, no rsp_valid, and the latched request is discarded.

Verification
REQ-035 Write addr 13'h0014, data 8'hA5, CLK_DIV=4 -> MOSI bits 24'h0014A5; ss_n low cycles 1..196; rsp_valid at cycle 197; rsp_rdata=8'h00.
REQ-036 Read addr 13'h0001, slave drives 8'h82 -> instruction 16'h8001; sdio_t rises after bit 16; rsp_rdata=8'h82 at rsp_valid.
REQ-037 req_valid held high continuously with two queued writes -> second ss_n fall exactly 2*CLK_DIV+1 cycles after the first ss_n rise; no extra frame.
REQ-038 req_valid pulsed mid-SHIFT with different addr -> ignored; the current frame is unchanged and only one rsp_valid occurs.
REQ-039 resetn low for 1 cycle at bit 10 of a read -> ss_n=1 and sdio_t=1 next cycle, no rsp_valid; a following write completes normally.
REQ-040 CLK_DIV=2 read/write loopback against the SPI slave register model -> read-back equals the written value at each of 4 addresses.
